// File: rtl/s_p_rx.sv
// s_p_rx -- serial-to-parallel receiver for the one-bit serial link.
//
// Samples Dbit_in on every rising clk edge while link_S_in is high, MSB
// first, and rebuilds a WIDTH-bit word. A frame is good when the strobe
// stays high for exactly WIDTH cycles.
//   * A good frame updates data_out, pulses out_valid and bumps frame_cnt.
//   * A frame that is too short pulses frame_err and is discarded.
//   * A frame that is too long pulses overrun_err and is discarded.
//
// All outputs are registered. Reset is synchronous and active-low.
//
// Ports
//   clk          system clock, rising edge
//   nRst         synchronous active-low reset
//   Dbit_in      serial data bit, valid while link_S_in=1
//   link_S_in    link-active strobe
//   data_out     last good word; holds between frames
//   out_valid    one-cycle pulse when data_out updates
//   frame_err    one-cycle pulse: strobe dropped before WIDTH bits
//   overrun_err  one-cycle pulse: strobe still high after WIDTH bits
//   frame_cnt    count of good frames, wraps
//
// state | meaning
// IDLE  | waiting for the strobe; the first high cycle is sampled here
// SHIFT | collecting bits; a strobe drop ends the frame
// DRAIN | overrun seen; ignore the link until the strobe drops

module s_p_rx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             Dbit_in,
  input  logic             link_S_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             frame_err,
  output logic             overrun_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BC_W = $clog2(WIDTH + 1);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun_err;
  logic [CNT_W-1:0] r_frame_cnt;

  logic [WIDTH-1:0] w_shift_next;
  logic             w_full;

  assign w_shift_next = {r_shift[WIDTH-2:0], Dbit_in};
  assign w_full       = (r_bit_cnt == BC_FULL);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      // Pulses default low so each is high for exactly one cycle.
      r_valid       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;

      case (r_state)
        IDLE: begin
          if (link_S_in) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= BC_W'(1);
            r_state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (link_S_in) begin
            if (w_full) begin
              // A WIDTH+1th bit: the frame is bad, wait out the strobe.
              r_overrun_err <= 1'b1;
              r_bit_cnt     <= '0;
              r_state       <= DRAIN;
            end else begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
          end else begin
            if (w_full) begin
              r_data      <= r_shift;
              r_valid     <= 1'b1;
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end else begin
              r_frame_err <= 1'b1;
            end
            r_bit_cnt <= '0;
            r_state   <= IDLE;
          end
        end

        DRAIN: begin
          if (!link_S_in) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_bit_cnt <= '0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign data_out    = r_data;
  assign out_valid   = r_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_s_p_rx.sv
// Directed testbench for s_p_rx (WIDTH=8, CNT_W=8).
// Inputs are driven and outputs sampled on the falling edge of clk.

module tb_s_p_rx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             nRst;
  logic             Dbit_in;
  logic             link_S_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             frame_err;
  logic             overrun_err;
  logic [CNT_W-1:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse tallies kept by the monitor; tests compare differences from a base.
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_oerr  = 0;
  int         n_multi = 0;
  logic [7:0] data_hist [0:511];

  int b_valid, b_ferr, b_oerr, b_multi;

  s_p_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk         (clk),
    .nRst        (nRst),
    .Dbit_in     (Dbit_in),
    .link_S_in   (link_S_in),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      data_hist[n_valid[8:0]] = data_out;
      n_valid = n_valid + 1;
    end
    if (frame_err)   n_ferr = n_ferr + 1;
    if (overrun_err) n_oerr = n_oerr + 1;
    if ((int'(out_valid) + int'(frame_err) + int'(overrun_err)) > 1)
      n_multi = n_multi + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap_base();
    b_valid = n_valid;
    b_ferr  = n_ferr;
    b_oerr  = n_oerr;
    b_multi = n_multi;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRst      = 1'b0;
    link_S_in = 1'b0;
    Dbit_in   = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    snap_base();
  endtask

  // Strobe high for len cycles, MSB of word first, then one low cycle.
  task automatic send_frame(input logic [15:0] word, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      link_S_in = 1'b1;
      Dbit_in   = word[len-1-i];
    end
    @(negedge clk);
    link_S_in = 1'b0;
    Dbit_in   = 1'b0;
  endtask

  initial begin
    nRst      = 1'b0;
    link_S_in = 1'b0;
    Dbit_in   = 1'b0;

    // Reset with strobe toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      link_S_in = ~link_S_in;
      Dbit_in   = 1'b1;
    end
    @(negedge clk);
    check_eq("rst_data",  32'(data_out),    32'h0);
    check_eq("rst_valid", 32'(out_valid),   32'h0);
    check_eq("rst_ferr",  32'(frame_err),   32'h0);
    check_eq("rst_oerr",  32'(overrun_err), 32'h0);
    check_eq("rst_cnt",   32'(frame_cnt),   32'h0);
    link_S_in = 1'b0;
    nRst      = 1'b1;
    snap_base();

    // First frame 0xA5; out_valid visible one cycle after the low cycle
    send_frame(16'h00A5, 8);
    @(negedge clk);
    check_eq("a5_valid", 32'(out_valid), 32'h1);
    check_eq("a5_data",  32'(data_out),  32'hA5);
    check_eq("a5_cnt",   32'(frame_cnt), 32'h1);
    @(negedge clk);
    check_eq("a5_valid_drop", 32'(out_valid), 32'h0);
    check_eq("a5_data_hold",  32'(data_out),  32'hA5);

    // Back-to-back frames with one low cycle between
    do_reset();
    send_frame(16'h003C, 8);
    send_frame(16'h00FF, 8);
    send_frame(16'h0000, 8);
    repeat (3) @(negedge clk);
    check_eq("b2b_nvalid", 32'(n_valid - b_valid), 32'd3);
    check_eq("b2b_d0", 32'(data_hist[9'(b_valid)]),     32'h3C);
    check_eq("b2b_d1", 32'(data_hist[9'(b_valid + 1)]), 32'hFF);
    check_eq("b2b_d2", 32'(data_hist[9'(b_valid + 2)]), 32'h00);
    check_eq("b2b_cnt", 32'(frame_cnt), 32'd3);
    check_eq("b2b_nerr", 32'(n_ferr - b_ferr + n_oerr - b_oerr), 32'd0);

    // Short frame after a good 0x5A
    do_reset();
    send_frame(16'h005A, 8);
    send_frame(16'h001F, 5);
    @(negedge clk);
    check_eq("short_ferr_pulse", 32'(frame_err), 32'h1);
    repeat (2) @(negedge clk);
    check_eq("short_nferr",  32'(n_ferr - b_ferr),   32'd1);
    check_eq("short_nvalid", 32'(n_valid - b_valid), 32'd1);
    check_eq("short_data",   32'(data_out),  32'h5A);
    check_eq("short_cnt",    32'(frame_cnt), 32'd1);

    // Overrun: strobe high 11 cycles
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 9) check_eq("ovr_pulse_9th", 32'(overrun_err), 32'h1);
      if (i == 8) check_eq("ovr_none_8th",  32'(overrun_err), 32'h0);
      link_S_in = 1'b1;
      Dbit_in   = i[0];
    end
    @(negedge clk);
    link_S_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("ovr_noerr",  32'(n_oerr - b_oerr),   32'd1);
    check_eq("ovr_nvalid", 32'(n_valid - b_valid), 32'd0);
    check_eq("ovr_nferr",  32'(n_ferr - b_ferr),   32'd0);
    send_frame(16'h0081, 8);
    repeat (2) @(negedge clk);
    check_eq("ovr_next_data",   32'(data_out),          32'h81);
    check_eq("ovr_next_nvalid", 32'(n_valid - b_valid), 32'd1);
    check_eq("ovr_next_cnt",    32'(frame_cnt),         32'd1);

    // Reset mid-frame, then 0xC3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      link_S_in = 1'b1;
      Dbit_in   = 1'b1;
    end
    @(negedge clk);
    nRst      = 1'b0;
    link_S_in = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    send_frame(16'h00C3, 8);
    repeat (2) @(negedge clk);
    check_eq("mid_nerr", 32'(n_ferr - b_ferr + n_oerr - b_oerr), 32'd0);
    check_eq("mid_data",   32'(data_out),          32'hC3);
    check_eq("mid_cnt",    32'(frame_cnt),         32'd1);
    check_eq("mid_nvalid", 32'(n_valid - b_valid), 32'd1);

    // Counter wrap over 256 good frames
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_frame(16'h0011, 8);
      if (i == 254) begin
        @(negedge clk);
        check_eq("wrap_cnt_255", 32'(frame_cnt), 32'd255);
      end
    end
    repeat (2) @(negedge clk);
    check_eq("wrap_cnt_0",   32'(frame_cnt),         32'd0);
    check_eq("wrap_nvalid",  32'(n_valid - b_valid), 32'd256);
    check_eq("wrap_data",    32'(data_out),          32'h11);

    // Pulses never overlapped during the whole run
    check_eq("pulse_excl", 32'(n_multi), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
